// File: rtl/ula_arbiter_if.sv
// Bundle of client-side request/response and ULA-side handshake signals for ula_arbiter.
// master = the arbiter, slave = clients plus the ULA instance.
interface ula_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] req_A;
    logic [16*N_REQ-1:0] req_B;
    logic [2*N_REQ-1:0]  req_instru;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    resp_valid;
    logic [31:0]         resp_data;
    logic                resp_err;
    logic                busy;
    logic [15:0]         ula_A;
    logic [15:0]         ula_B;
    logic [1:0]          ula_instru;
    logic                ula_valid;
    logic [31:0]         ula_data_out;
    logic                ula_valid_out;

    modport master (
        input  req, req_A, req_B, req_instru, ula_data_out, ula_valid_out,
        output gnt, resp_valid, resp_data, resp_err, busy,
               ula_A, ula_B, ula_instru, ula_valid
    );

    modport slave (
        output req, req_A, req_B, req_instru, ula_data_out, ula_valid_out,
        input  gnt, resp_valid, resp_data, resp_err, busy,
               ula_A, ula_B, ula_instru, ula_valid
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin scheduler sharing one ULA between N_REQ clients, one operation in flight,
// with a watchdog that aborts an operation whose result never arrives.
module ula_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk_ula,
    input  logic          rst,
    ula_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    b_q, b_d;
    logic [1:0]     instru_q, instru_d;
    logic [31:0]    data_q, data_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic [IDW-1:0] cand [N_REQ];
    logic           win_found;
    logic [IDW-1:0] win_id;

    // cand[k] is the client examined k-th, starting from rr_ptr and wrapping at N_REQ
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum      = {1'b0, rr_ptr_q} + (IDW+1)'(gi);
            assign cand[gi] = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ))
                                                       : sum[IDW-1:0];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[cand[k]]) begin
                win_found = 1'b1;
                win_id    = cand[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        instru_d = instru_q;
        data_d   = data_q;
        err_d    = err_q;
        wdog_d   = wdog_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    a_d      = bus.req_A[16*win_id +: 16];
                    b_d      = bus.req_B[16*win_id +: 16];
                    instru_d = bus.req_instru[2*win_id +: 2];
                    id_d     = win_id;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                err_d  = 1'b0;
                wdog_d = '0;
                if (bus.ula_valid_out) begin
                    data_d  = bus.ula_data_out;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // abort lands RESP exactly TIMEOUT cycles after the ISSUE cycle
                if (bus.ula_valid_out) begin
                    data_d  = bus.ula_data_out;
                    state_d = ST_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 2)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            default: begin
                rr_ptr_d = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ula) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            instru_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            instru_q <= instru_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    // gnt is suppressed while reset is held so no client sees a phantom accept
    always_comb begin
        bus.gnt = '0;
        if (rst && (state_q == ST_IDLE) && win_found) begin
            bus.gnt[win_id] = 1'b1;
        end
    end

    always_comb begin
        bus.resp_valid = '0;
        if (state_q == ST_RESP) begin
            bus.resp_valid[id_q] = 1'b1;
        end
    end

    assign bus.resp_data  = (state_q == ST_RESP) ? data_q : '0;
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.ula_A      = a_q;
    assign bus.ula_B      = b_q;
    assign bus.ula_instru = instru_q;
    assign bus.ula_valid  = (state_q == ST_ISSUE);
endmodule
